// File: rtl/rat_flag_unit.sv
// rat_flag_unit: RAT CPU carry/zero flags, interrupt shadow, interrupt enable/pend, branch condition
//   CLK, RST          clock, synchronous active-high reset
//   C_IN, Z_IN        ALU carry/zero results
//   FLG_*             flag load/set/clear, load source select, shadow save
//   I_SET, I_CLR      interrupt enable control
//   INTR_IN, INT_ACK  async interrupt request, control-unit acknowledge
//   BR_COND           branch condition code
//   C_FLAG, Z_FLAG, I_FLAG, INT_PEND, PC_LD_BR  flag and control outputs
module rat_flag_unit #(
    parameter int unsigned INT_SYNC_STAGES = 2,
    parameter bit          EDGE_DETECT     = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       C_IN,
    input  logic       Z_IN,
    input  logic       FLG_C_LD,
    input  logic       FLG_Z_LD,
    input  logic       FLG_C_SET,
    input  logic       FLG_C_CLR,
    input  logic       FLG_LD_SEL,
    input  logic       FLG_SHAD_LD,
    input  logic       I_SET,
    input  logic       I_CLR,
    input  logic       INTR_IN,
    input  logic       INT_ACK,
    input  logic [2:0] BR_COND,
    output logic       C_FLAG,
    output logic       Z_FLAG,
    output logic       I_FLAG,
    output logic       INT_PEND,
    output logic       PC_LD_BR
);
    logic                       shad_c, shad_z, pend, intr_d;
    logic [INT_SYNC_STAGES-1:0] sync;
    logic                       intr_s, pend_ev, ack;
    assign intr_s   = sync[INT_SYNC_STAGES-1];
    assign pend_ev  = EDGE_DETECT ? (intr_s & ~intr_d) : intr_s;
    // an acknowledge only counts while the request is actually presented
    assign ack      = INT_ACK & INT_PEND;
    assign INT_PEND = pend & I_FLAG;
    always_ff @(posedge CLK) begin
        if (RST) begin
            C_FLAG <= 1'b0;
            Z_FLAG <= 1'b0;
            shad_c <= 1'b0;
            shad_z <= 1'b0;
            I_FLAG <= 1'b0;
            pend   <= 1'b0;
            intr_d <= 1'b0;
            sync   <= '0;
        end else begin
            C_FLAG <= FLG_C_CLR ? 1'b0 : FLG_C_SET ? 1'b1 :
                      FLG_C_LD ? (FLG_LD_SEL ? shad_c : C_IN) : C_FLAG;
            Z_FLAG <= FLG_Z_LD ? (FLG_LD_SEL ? shad_z : Z_IN) : Z_FLAG;
            // shadow takes pre-edge flags, so save+restore swaps
            if (FLG_SHAD_LD) begin
                shad_c <= C_FLAG;
                shad_z <= Z_FLAG;
            end
            I_FLAG <= (ack | I_CLR) ? 1'b0 : I_SET ? 1'b1 : I_FLAG;
            // a new request beats a simultaneous acknowledge
            pend   <= pend_ev | (pend & ~ack);
            intr_d <= intr_s;
            sync   <= {sync[INT_SYNC_STAGES-2:0], INTR_IN};
        end
    end
    always_comb begin
        case (BR_COND)
            3'd1:    PC_LD_BR = C_FLAG;
            3'd2:    PC_LD_BR = ~C_FLAG;
            3'd3:    PC_LD_BR = Z_FLAG;
            3'd4:    PC_LD_BR = ~Z_FLAG;
            3'd5:    PC_LD_BR = 1'b1;
            default: PC_LD_BR = 1'b0;
        endcase
    end
endmodule

// File: doc/rat_flag_unit.md
Name: rat_flag_unit

Overview:
- Sequential flag unit on the far side of the ALU's C/Z/CIN interface in the RAT CPU.
- Registers C and Z from the ALU and feeds C back as the ALU carry-in.
- Holds shadow copies of C and Z across interrupts, manages the interrupt-enable flag and a pending-interrupt latch.
- Evaluates branch conditions for the control unit.

Parameters:
- INT_SYNC_STAGES, 2, number of flip-flop stages synchronising INTR_IN (minimum 2).
- EDGE_DETECT, 1, 1 = pend on rising edge of synchronised INTR; 0 = pend on level.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- C_IN  in  1  carry from ALU
- Z_IN  in  1  zero from ALU
- FLG_C_LD  in  1  load C from selected source
- FLG_Z_LD  in  1  load Z from selected source
- FLG_C_SET  in  1  force C=1 (SEC)
- FLG_C_CLR  in  1  force C=0 (CLC)
- FLG_LD_SEL  in  1  load source: 0 = ALU (C_IN/Z_IN), 1 = shadow (RETID/RETIE restore)
- FLG_SHAD_LD  in  1  copy current C/Z into shadow (interrupt entry)
- I_SET  in  1  set interrupt enable (SEI)
- I_CLR  in  1  clear interrupt enable (CLI)
- INTR_IN  in  1  asynchronous external interrupt request
- INT_ACK  in  1  control unit accepts interrupt, one-cycle pulse
- BR_COND  in  3  0 none, 1 BRCS, 2 BRCC, 3 BREQ, 4 BRNE, 5 BRN (always), 6-7 none
- C_FLAG  out  1  registered carry, also ALU CIN
- Z_FLAG  out  1  registered zero
- I_FLAG  out  1  interrupt enable
- INT_PEND  out  1  interrupt request to control unit
- PC_LD_BR  out  1  branch taken

Behaviour:
- Reset:
  - On a CLK edge with RST=1, C, Z, SHAD_C, SHAD_Z, I_FLAG, the pend latch, the synchroniser chain and the edge-detect register all go to 0.
  - RST overrides every other input in the same cycle and aborts any pending interrupt.
- C register priority, highest first: RST > FLG_C_CLR > FLG_C_SET > FLG_C_LD.
  - FLG_C_LD loads C_IN when FLG_LD_SEL=0, SHAD_C when FLG_LD_SEL=1.
  - With no control active, C holds.
- Z register: RST > FLG_Z_LD, which loads Z_IN or SHAD_Z per FLG_LD_SEL. Otherwise Z holds.
- Shadow registers:
  - FLG_SHAD_LD copies pre-edge C_FLAG/Z_FLAG.
  - When a save and a flag load occur in the same cycle, the shadow gets the old values and the flags get the new ones.
  - When a restore and a save occur in the same cycle, the flags get the old shadow and the shadow gets the old flags (swap).
- Latency: every flag update is visible on the outputs one cycle after the load. Outputs are driven directly from registers; no combinational path from C_IN/Z_IN to C_FLAG/Z_FLAG.
- I_FLAG priority: RST > INT_ACK (clears) > I_CLR > I_SET > hold.
- Interrupt path:
  - INTR_IN passes through INT_SYNC_STAGES flops, giving intr_s.
  - EDGE_DETECT=1: a pend event is intr_s=1 with previous intr_s=0.
  - EDGE_DETECT=0: a pend event is intr_s=1.
  - A pend event sets the pend latch. INT_ACK clears it. If both occur in the same cycle, the set wins and the latch stays 1.
  - INT_PEND = pend AND I_FLAG (combinational from registers). With I_FLAG=0 a request stays latched and asserts INT_PEND once I_FLAG becomes 1.
  - INT_ACK while INT_PEND=0 is ignored: no change to pend or I_FLAG.
- Branch evaluation: PC_LD_BR is combinational from the registered flags and BR_COND.
  - BRCS: C=1. BRCC: C=0. BREQ: Z=1. BRNE: Z=0. BRN: 1. Codes 0, 6, 7: 0.
  - A branch in the cycle after a flag load sees the updated flag.

Test Plan:
- Reset: load C=1, Z=1, I=1, pend=1; pulse RST -> next cycle all outputs 0, INT_PEND 0.
- Flag load and priority:
  - C_IN=1, Z_IN=0, FLG_C_LD=FLG_Z_LD=1 -> C_FLAG=1, Z_FLAG=0 one cycle later.
  - FLG_C_CLR=FLG_C_SET=FLG_C_LD=1 with C_IN=1 -> C_FLAG=0.
- Shadow save/restore: C=1, Z=0; FLG_SHAD_LD with ALU load C_IN=0, Z_IN=1 -> flags 0/1, shadow 1/0. Then FLG_LD_SEL=1 with both loads -> flags back to 1/0.
- Interrupt, EDGE_DETECT=1, I_FLAG=1:
  - Raise INTR_IN and hold it -> INT_PEND rises INT_SYNC_STAGES+1 cycles later.
  - INT_ACK -> next cycle INT_PEND=0 and I_FLAG=0. INTR_IN still high does not re-pend.
- Masked request: I_FLAG=0, pulse INTR_IN -> INT_PEND stays 0. I_SET -> INT_PEND=1 next cycle. Edge coinciding with INT_ACK -> pend stays 1.
- Branch sweep: for each C/Z combination, sweep BR_COND 0-7 -> PC_LD_BR matches the table. BRN is always 1; codes 0, 6, 7 are always 0.
